serial_adder: RTL

- Bit-serial N-bit adder built around the existing single-bit full adder.
- Latches two operands and a carry-in on start, then feeds one bit pair per clock, LSB first, through one full adder.
- A carry flip-flop links each bit to the next.
- Sits downstream of operand registers. It is the sequential stage that consumes the fulladd cell, trading latency for area against a ripple-carry array.

---
 rtl/adder_pkg.sv | 17 +
 rtl/fulladd.sv | 22 ++
 rtl/serial_adder.sv | 102 ++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared state encoding and default width for the serial adder.
// Revision : 1.0
// ============================================================================
package adder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int c_DEFAULT_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/fulladd.sv
`default_nettype none
// ============================================================================
// Module   : fulladd
// Brief    : Single-bit full adder cell.
// Revision : 1.0
// ============================================================================
module fulladd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign sum  = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial WIDTH-bit adder, one bit per clock LSB first, using a
//            single fulladd cell and a carry flop.
// Revision : 1.0
// ============================================================================
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_res_next;

    fulladd u_fulladd (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 is the LSB.
    generate
        if (WIDTH == 1) begin : g_res_single
            assign w_res_next = w_fa_sum;
        end else begin : g_res_multi
            assign w_res_next = {w_fa_sum, r_res_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_carry  <= w_fa_cout;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Outputs update only here so partial sums never leak out.
                    if (r_cnt == c_LAST) begin
                        sum     <= w_res_next;
                        cout    <= w_fa_cout;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
